// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/MEM requesters, the memory bus and mem_bus_arbiter.
// The arbiter connects through `master`, and the requester/memory side connects through `slave`.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_vd;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_vd;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        err_sticky;
    logic        err_clr;

    modport master (
        input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, dm_wstrb,
               bus_ack, bus_rdata, err_clr,
        output if_rdata, if_vd, dm_rdata, dm_vd, bus_req, bus_we, bus_addr,
               bus_wdata, bus_wstrb, bus_err, err_sticky
    );

    modport slave (
        output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, dm_wstrb,
               bus_ack, bus_rdata, err_clr,
        input  if_rdata, if_vd, dm_rdata, dm_vd, bus_req, bus_we, bus_addr,
               bus_wdata, bus_wstrb, bus_err, err_sticky
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and MEM-stage load/store.
// Data has priority, fetch is protected from starvation, and hung transactions time out.
module mem_bus_arbiter #(
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(MAX_DM_STREAK + 2);

    typedef enum logic [1:0] {StIdle, StIfWait, StDmWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timed_out_q, timed_out_d;
    logic          owner_dm_q, owner_dm_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          err_sticky_q, err_sticky_d;
    logic          dm_req, dm_win, bus_err;

    assign bus_err = (state_q == StResp) && timed_out_q;

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        timed_out_d  = timed_out_q;
        owner_dm_d   = owner_dm_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        dm_req       = bus.dm_re | bus.dm_we;
        dm_win       = 1'b0;

        case (state_q)
            StIdle: begin
                tmo_d       = '0;
                timed_out_d = 1'b0;
                if (dm_req || bus.if_req) begin
                    dm_win     = dm_req && !(bus.if_req && streak_q == SW'(MAX_DM_STREAK));
                    owner_dm_d = dm_win;
                    if (dm_win) begin
                        state_d     = StDmWait;
                        bus_we_d    = bus.dm_we;
                        bus_addr_d  = bus.dm_addr;
                        bus_wdata_d = bus.dm_wdata;
                        bus_wstrb_d = bus.dm_wstrb;
                        // A DM win with fetch pending implies streak < MAX, so +1 cannot overshoot.
                        streak_d    = bus.if_req ? streak_q + SW'(1) : '0;
                    end else begin
                        state_d     = StIfWait;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = bus.if_addr;
                        bus_wdata_d = '0;
                        bus_wstrb_d = 4'hF;
                        streak_d    = '0;
                    end
                end
            end
            StIfWait, StDmWait: begin
                if (bus.bus_ack) begin
                    state_d = StResp;
                    if (owner_dm_q) dm_rdata_d = bus.bus_rdata;
                    else            if_rdata_d = bus.bus_rdata;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Last allowed wait cycle passed without ack: abort with zero data.
                    state_d     = StResp;
                    timed_out_d = 1'b1;
                    if (owner_dm_q) dm_rdata_d = '0;
                    else            if_rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        err_sticky_d = bus_err | (err_sticky_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            streak_q     <= '0;
            tmo_q        <= '0;
            timed_out_q  <= 1'b0;
            owner_dm_q   <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            timed_out_q  <= timed_out_d;
            owner_dm_q   <= owner_dm_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.bus_req    = (state_q == StIfWait) || (state_q == StDmWait);
    assign bus.bus_we     = bus_we_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_wdata  = bus_wdata_q;
    assign bus.bus_wstrb  = bus_wstrb_q;
    assign bus.if_vd      = (state_q == StResp) && !owner_dm_q;
    assign bus.dm_vd      = (state_q == StResp) && owner_dm_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.bus_err    = bus_err;
    assign bus.err_sticky = err_sticky_q;
endmodule
